// File: rtl/param_shift_queue.sv
// Shift queue of DEPTH x WIDTH entries (slot[0] newest) with occupancy, pop-oldest, flush and sticky flags.
// Push/pop are rising-edge detected; define PARAM_SHIFT_QUEUE_LEVEL_TRIG_EN for level-triggered operation.
module param_shift_queue #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ENA,
    input  logic                     POP,
    input  logic                     CLR,
    input  logic [WIDTH-1:0]         DATAIN,
    output logic [WIDTH*DEPTH-1:0]   DATAOUT,
    output logic [WIDTH-1:0]         OLDEST,
    output logic [CW-1:0]            COUNT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     OVERFLOW,
    output logic                     UNDERFLOW
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [WIDTH-1:0] slot_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             push_ev, pop_ev;
    logic             do_shift;

`ifdef PARAM_SHIFT_QUEUE_LEVEL_TRIG_EN
    assign push_ev = ENA;
    assign pop_ev  = POP;
`else
    logic ena_prev_q;
    logic pop_prev_q;

    // Edge history keeps sampling during CLR so a held request does not re-fire afterwards.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ena_prev_q <= 1'b0;
            pop_prev_q <= 1'b0;
        end else begin
            ena_prev_q <= ENA;
            pop_prev_q <= POP;
        end
    end

    assign push_ev = ENA & ~ena_prev_q;
    assign pop_ev  = POP & ~pop_prev_q;
`endif

    always_comb begin
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        do_shift = 1'b0;

        if (push_ev && pop_ev) begin
            // The popped entry is the one shifted out or masked, so occupancy holds.
            do_shift = 1'b1;
            if (count_q == '0) begin
                count_d = CW'(1);
                udf_d   = 1'b1;
            end
        end else if (push_ev) begin
            do_shift = 1'b1;
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (pop_ev) begin
            if (count_q == '0) begin
                udf_d = 1'b1;
            end else begin
                count_d = count_q - CW'(1);
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
            if (do_shift) begin
                slot_d[i] = (i == 0) ? DATAIN : slot_q[(i == 0) ? 0 : i - 1];
            end
            // Everything at or beyond the new occupancy reads as zero.
            if (CW'(i) >= count_d) begin
                slot_d[i] = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_comb begin
        DATAOUT = '0;
        OLDEST  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            DATAOUT[i*WIDTH +: WIDTH] = slot_q[i];
            if (count_q == CW'(i + 1)) begin
                OLDEST = slot_q[i];
            end
        end
    end

    assign COUNT     = count_q;
    assign EMPTY     = (count_q == '0);
    assign FULL      = (count_q == CNT_MAX);
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = udf_q;

endmodule

// File: tb/tb_param_shift_queue.sv
// Directed bench for param_shift_queue: default 8x4 instance plus a 16x3 instance.
module tb_param_shift_queue;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ENA = 1'b0;
    logic        POP = 1'b0;
    logic        CLR = 1'b0;
    logic [7:0]  DATAIN = '0;
    logic [31:0] DATAOUT;
    logic [7:0]  OLDEST;
    logic [2:0]  COUNT;
    logic        EMPTY, FULL, OVERFLOW, UNDERFLOW;

    logic        ENA2 = 1'b0;
    logic [15:0] DATAIN2 = '0;
    logic [47:0] DATAOUT2;
    logic [15:0] OLDEST2;
    logic [1:0]  COUNT2;
    logic        EMPTY2, FULL2, OVERFLOW2, UNDERFLOW2;

    int n_chk = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    param_shift_queue dut (
        .CLK(CLK), .RST(RST), .ENA(ENA), .POP(POP), .CLR(CLR), .DATAIN(DATAIN),
        .DATAOUT(DATAOUT), .OLDEST(OLDEST), .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    param_shift_queue #(.WIDTH(16), .DEPTH(3)) dut2 (
        .CLK(CLK), .RST(RST), .ENA(ENA2), .POP(1'b0), .CLR(1'b0), .DATAIN(DATAIN2),
        .DATAOUT(DATAOUT2), .OLDEST(OLDEST2), .COUNT(COUNT2), .EMPTY(EMPTY2), .FULL(FULL2),
        .OVERFLOW(OVERFLOW2), .UNDERFLOW(UNDERFLOW2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        DATAIN = d;
        ENA = 1'b1;
        step();
        ENA = 1'b0;
        step();
    endtask

    task automatic pop();
        POP = 1'b1;
        step();
        POP = 1'b0;
        step();
    endtask

    task automatic flush();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        step();
    endtask

    task automatic fill4();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    endtask

    localparam logic [15:0] D2 [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

    initial begin
        step(); step();
        RST = 1'b0;
        step();
        chk("rst_dataout", DATAOUT, 0);
        chk("rst_oldest", OLDEST, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_flags", {OVERFLOW, UNDERFLOW}, 0);
        chk("rst_dataout2", DATAOUT2, 0);

        fill4();
        chk("fill_dataout", DATAOUT, 32'h11223344);
        chk("fill_count", COUNT, 4);
        chk("fill_full", FULL, 1);
        chk("fill_oldest", OLDEST, 8'h11);
        chk("fill_ovf", OVERFLOW, 0);

        push(8'h55);
        chk("ovf_dataout", DATAOUT, 32'h22334455);
        chk("ovf_oldest", OLDEST, 8'h22);
        chk("ovf_count", COUNT, 4);
        chk("ovf_flag", OVERFLOW, 1);
        repeat (10) step();
        chk("ovf_sticky", OVERFLOW, 1);

        flush();
        chk("clr_count", COUNT, 0);
        chk("clr_ovf", OVERFLOW, 0);

        DATAIN = 8'hA5;
        ENA = 1'b1;
        repeat (5) step();
        ENA = 1'b0;
        step();
`ifdef PARAM_SHIFT_QUEUE_LEVEL_TRIG_EN
        chk("hold_count", COUNT, 4);
        chk("hold_dataout", DATAOUT, 32'hA5A5A5A5);
        chk("hold_ovf", OVERFLOW, 1);
`else
        chk("hold_count", COUNT, 1);
        chk("hold_dataout", DATAOUT, 32'h000000A5);
        chk("hold_ovf", OVERFLOW, 0);
`endif

        flush();
        push(8'h22); push(8'h33);
        chk("pop_pre_oldest", OLDEST, 8'h22);
        pop();
        chk("pop1_count", COUNT, 1);
        chk("pop1_oldest", OLDEST, 8'h33);
        chk("pop1_dataout", DATAOUT, 32'h00000033);
        chk("pop1_udf", UNDERFLOW, 0);
        pop();
        chk("pop2_empty", EMPTY, 1);
        chk("pop2_udf", UNDERFLOW, 0);
        pop();
        chk("pop3_empty", EMPTY, 1);
        chk("pop3_udf", UNDERFLOW, 1);

        flush();
        fill4();
        DATAIN = 8'h66; ENA = 1'b1; POP = 1'b1;
        step();
        ENA = 1'b0; POP = 1'b0;
        step();
        chk("pp_full_count", COUNT, 4);
        chk("pp_full_ovf", OVERFLOW, 0);
        chk("pp_full_oldest", OLDEST, 8'h22);
        chk("pp_full_dataout", DATAOUT, 32'h22334466);

        DATAIN = 8'h77; ENA = 1'b1; CLR = 1'b1;
        step();
        CLR = 1'b0; ENA = 1'b0;
        chk("clr_ena_dataout", DATAOUT, 0);
        chk("clr_ena_empty", EMPTY, 1);
        chk("clr_ena_flags", {OVERFLOW, UNDERFLOW}, 0);
        step();
        chk("clr_ena_after", COUNT, 0);

        DATAIN = 8'h99; ENA = 1'b1; POP = 1'b1;
        step();
        ENA = 1'b0; POP = 1'b0;
        step();
        chk("pp_empty_count", COUNT, 1);
        chk("pp_empty_udf", UNDERFLOW, 1);
        chk("pp_empty_dataout", DATAOUT, 32'h00000099);

        flush();
        push(8'hAA); push(8'hBB);
        DATAIN = 8'hCC; ENA = 1'b1; POP = 1'b1;
        step();
        ENA = 1'b0; POP = 1'b0;
        step();
        chk("pp_mid_count", COUNT, 2);
        chk("pp_mid_dataout", DATAOUT, 32'h0000BBCC);
        chk("pp_mid_oldest", OLDEST, 8'hBB);

        RST = 1'b1; CLR = 1'b1;
        step();
        CLR = 1'b0;
        DATAIN = 8'h5A; ENA = 1'b1;
        step();
        chk("rst2_count", COUNT, 0);
        chk("rst2_dataout", DATAOUT, 0);
        RST = 1'b0;
        step();
        ENA = 1'b0;
        step();
        chk("rst_rel_count", COUNT, 1);
        chk("rst_rel_dataout", DATAOUT, 32'h0000005A);

`ifdef PARAM_SHIFT_QUEUE_LEVEL_TRIG_EN
        ENA2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            DATAIN2 = D2[i];
            step();
        end
        ENA2 = 1'b0;
        step();
`else
        for (int i = 0; i < 4; i++) begin
            DATAIN2 = D2[i];
            ENA2 = 1'b1;
            step();
            ENA2 = 1'b0;
            step();
        end
`endif
        chk("w16_dataout", DATAOUT2, 48'h56789ABCDEF0);
        chk("w16_ovf", OVERFLOW2, 1);
        chk("w16_count", COUNT2, 3);
        chk("w16_oldest", OLDEST2, 16'h5678);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
